fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the MIPS core. Owns the architectural fetch PC, and issues one instruction request at a time on the SRAM-like instruction bus. Delivers each fetched word to the decode stage with a valid/stall handshake. Applies branch and exception redirects without losing the branch delay slot.

## Interface
- WIDTH, 32, address/data width
- RESET_PC, 32'hbfc00000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  decode cannot accept an instruction this cycle
- branch_taken_i  in  1  branch/jump resolved taken (one-cycle pulse)
- branch_target_i  in  WIDTH  branch/jump target
- exc_i  in  1  exception/eret flush (one-cycle pulse)
- exc_target_i  in  WIDTH  handler or EPC address
- inst_req  out  1  fetch request
- inst_addr  out  WIDTH  fetch address; bits [1:0] always 0
- inst_addr_ok  in  1  address accepted (sampled only while inst_req=1)
- inst_data_ok  in  1  read data returned (sampled only in WAIT)
- inst_rdata  in  WIDTH  read data
- inst_valid_o  out  1  instruction available to decode
- inst_o  out  WIDTH  instruction word
- pc_o  out  WIDTH  PC of inst_o

## Operation
- States:
  - REQ: inst_req=1. Moves to WAIT on inst_addr_ok.
  - WAIT: request outstanding. Moves to HOLD on inst_data_ok, or back to REQ if the response is discarded.
  - HOLD: inst_valid_o=1. Moves to REQ when stall_i=0.
- Sequential next PC is pc+4, wrapping modulo 2^WIDTH.
- Branch: branch_taken_i in any state stores branch_target_i in a one-entry redirect buffer. The buffer is consumed by the next HOLD->REQ transition, so the instruction currently being fetched executes as the delay slot. A later branch before consumption overwrites the entry.
- Exception has top priority:
  - Clears the pending branch.
  - Drops any held instruction; inst_valid_o=0 next cycle.
  - Sets the fetch PC to exc_target_i.
  - exc_i and branch_taken_i in the same cycle: exc wins and the branch is lost.
- Exception by state:
  - REQ without inst_addr_ok: inst_addr switches to the target next cycle. The bus bridge permits address change before accept.
  - REQ with inst_addr_ok: go WAIT with discard flag set.
  - WAIT without inst_data_ok: set the discard flag.
  - WAIT with inst_data_ok: drop the data, go REQ.
  - HOLD: go REQ.
- Discarded response: on inst_data_ok with discard set, drop the data, clear the flag, go REQ at the redirected PC. No valid is produced.
- At most one outstanding request at any time.

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC, inst_addr=RESET_PC
  - inst_req=1 (held 0 while rst asserted)
  - inst_valid_o=0, inst_o=0, pc_o=0
  - redirect buffer empty, discard=0
- First request is visible the first cycle after rst deasserts.
- inst_addr_ok in the same cycle inst_req rises is accepted (zero-wait bus).
- Data-to-valid latency is 1 cycle: inst_o and pc_o are registered on inst_data_ok; inst_valid_o is high from the next cycle.
- inst_o, pc_o and inst_valid_o hold stable while stall_i=1.
- Handover cycle (HOLD, stall_i=0): the next cycle shows inst_valid_o=0 and inst_req=1 with the new address.
- Minimum throughput: one instruction per 3 cycles on a zero-wait bus.
- Reset mid-operation returns everything to reset values at once. The bridge is reset by the same rst, so no stale response arrives.

## Structure
- Shared package mycpu_defs holds RESET_PC and the fetch state enum (REQ/WAIT/HOLD).
- Sub-module redirect_buf holds the one-entry branch redirect:
  - Inputs: set, target, clear, consume.
  - Outputs: valid, target.
- Top level holds the FSM, PC register, discard flag and output registers.

## Test plan
- Reset release, zero-wait bus, stall_i=0: addresses are bfc00000, bfc00004, bfc00008. inst_valid_o pulses once per word with matching pc_o.
- 3-cycle data_ok delay plus stall_i held 4 cycles in HOLD: inst_o and pc_o stay constant. Exactly one request is in flight.
- Branch to 80001000 while fetching bfc00004 (WAIT): bfc00004 is delivered. Next inst_addr=80001000, not bfc00008.
- exc_i to bfc00380 in WAIT: late response is dropped with no valid. Next inst_addr=bfc00380.
- exc_i and branch_taken_i in the same cycle: fetch goes to exc_target_i and the branch target is never fetched.
- rst asserted in WAIT: inst_req=0 and inst_valid_o=0 immediately. After release, a request to bfc00000 is issued.

Source files
------------

// File: rtl/mycpu_defs.sv
// mycpu_defs: definitions shared across the MIPS core front end.
//   RESET_PC      - first fetch address after reset
//   fetch_state_t - instruction-fetch sequencer states
package mycpu_defs;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'hbfc00000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,   // request driven, waiting for address accept
        WAIT = 2'd1,   // request accepted, waiting for read data
        HOLD = 2'd2    // instruction presented to decode
    } fetch_state_t;

endpackage

// File: rtl/redirect_buf.sv
// redirect_buf: one-entry pending branch redirect.
//   clk, rst    - clock, asynchronous active-high reset
//   set         - store set_target (a later set overwrites the entry)
//   set_target  - branch/jump target to store
//   clear       - drop the entry (exception flush); wins over set
//   consume     - entry used by the fetch sequencer this cycle
//   valid       - an entry is pending
//   target      - pending target
module redirect_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [WIDTH-1:0] set_target,
    input  logic             clear,
    input  logic             consume,
    output logic             valid,
    output logic [WIDTH-1:0] target
);

    // A branch resolving in the consume cycle becomes the new pending entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (set) begin
            valid  <= 1'b1;
            target <= set_target;
        end else if (consume) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. One outstanding request on an
// SRAM-like bus, valid/stall handover to decode, branch redirect applied
// after the delay slot, exception flush with top priority.
//   clk, rst                         - clock, asynchronous active-high reset
//   stall_i                          - decode cannot accept this cycle
//   branch_taken_i, branch_target_i  - taken branch pulse and its target
//   exc_i, exc_target_i              - exception/eret flush pulse and target
//   inst_req, inst_addr              - fetch request and address
//   inst_addr_ok, inst_data_ok       - bus accept / read data return
//   inst_rdata                       - read data
//   inst_valid_o, inst_o, pc_o       - instruction to decode and its PC
module fetch_ctrl
    import mycpu_defs::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(mycpu_defs::RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             exc_i,
    input  logic [WIDTH-1:0] exc_target_i,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             inst_valid_o,
    output logic [WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0] pc_o
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic             discard;
    logic             rb_valid;
    logic [WIDTH-1:0] rb_target;
    logic             handover;
    logic [WIDTH-1:0] exc_pc;
    logic [WIDTH-1:0] next_seq_pc;

    // Word-aligned redirect targets keep inst_addr[1:0] at zero.
    assign exc_pc      = exc_target_i & ALIGN_MASK;
    assign next_seq_pc = rb_valid ? (rb_target & ALIGN_MASK) : (pc + PC_STEP);
    assign handover    = (state == HOLD) && !stall_i && !exc_i;

    // Request is gated by rst so it drops immediately on a mid-run reset.
    assign inst_req  = (state == REQ) && !rst;
    assign inst_addr = pc;

    redirect_buf #(.WIDTH(WIDTH)) u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .set        (branch_taken_i),
        .set_target (branch_target_i),
        .clear      (exc_i),
        .consume    (handover),
        .valid      (rb_valid),
        .target     (rb_target)
    );

    // Fetch FSM with PC, discard flag and decode-side output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= REQ;
            pc           <= RESET_PC;
            discard      <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            pc_o         <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (inst_addr_ok) begin
                        state <= WAIT;
                    end
                    // Before accept the address simply moves; after accept the
                    // in-flight response belongs to the old path.
                    if (exc_i) begin
                        pc <= exc_pc;
                        if (inst_addr_ok) begin
                            discard <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (discard || exc_i) begin
                            state   <= REQ;
                            discard <= 1'b0;
                        end else begin
                            state        <= HOLD;
                            inst_valid_o <= 1'b1;
                            inst_o       <= inst_rdata;
                            pc_o         <= pc;
                        end
                        if (exc_i) begin
                            pc <= exc_pc;
                        end
                    end else if (exc_i) begin
                        discard <= 1'b1;
                        pc      <= exc_pc;
                    end
                end
                HOLD: begin
                    if (exc_i) begin
                        state        <= REQ;
                        inst_valid_o <= 1'b0;
                        pc           <= exc_pc;
                    end else if (!stall_i) begin
                        state        <= REQ;
                        inst_valid_o <= 1'b0;
                        pc           <= next_seq_pc;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl with hand-computed
// expected addresses, instruction words and handshake levels.
module tb_fetch_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall_i;
    logic         branch_taken_i;
    logic [W-1:0] branch_target_i;
    logic         exc_i;
    logic [W-1:0] exc_target_i;
    logic         inst_req;
    logic [W-1:0] inst_addr;
    logic         inst_addr_ok;
    logic         inst_data_ok;
    logic [W-1:0] inst_rdata;
    logic         inst_valid_o;
    logic [W-1:0] inst_o;
    logic [W-1:0] pc_o;

    int n_vec = 0;
    int n_err = 0;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .exc_i           (exc_i),
        .exc_target_i    (exc_target_i),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .pc_o            (pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_req", W'(inst_req), W'(0));
        check("rst_valid", W'(inst_valid_o), W'(0));
        step();
        step();
        check("rst_addr", inst_addr, 32'hbfc00000);
        check("rst_inst", inst_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        rst = 1'b0;
        #1;
        check("rel_req", W'(inst_req), W'(1));
    endtask

    // Present the request at exp_addr and accept it on the same cycle.
    task automatic issue(input logic [W-1:0] exp_addr);
        check("req_hi", W'(inst_req), W'(1));
        check("req_valid_lo", W'(inst_valid_o), W'(0));
        check("req_addr", inst_addr, exp_addr);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        check("wait_req_lo", W'(inst_req), W'(0));
    endtask

    task automatic respond(input logic [W-1:0] data, input int delay);
        for (int i = 0; i < delay; i++) begin
            step();
            check("inflight_req", W'(inst_req), W'(0));
            check("inflight_valid", W'(inst_valid_o), W'(0));
        end
        inst_data_ok = 1'b1;
        inst_rdata   = data;
        step();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'hxxxxxxxx;
    endtask

    task automatic expect_hold(input logic [W-1:0] data, input logic [W-1:0] pc, input int stalls);
        check("hold_valid", W'(inst_valid_o), W'(1));
        check("hold_inst", inst_o, data);
        check("hold_pc", pc_o, pc);
        stall_i = 1'b1;
        for (int i = 0; i < stalls; i++) begin
            step();
            check("stall_valid", W'(inst_valid_o), W'(1));
            check("stall_inst", inst_o, data);
            check("stall_pc", pc_o, pc);
            check("stall_req", W'(inst_req), W'(0));
        end
        stall_i = 1'b0;
        step();
        check("handover_valid", W'(inst_valid_o), W'(0));
    endtask

    task automatic fetch_one(input logic [W-1:0] addr, input logic [W-1:0] data,
                             input int delay, input int stalls);
        issue(addr);
        respond(data, delay);
        expect_hold(data, addr, stalls);
    endtask

    task automatic pulse_branch(input logic [W-1:0] tgt);
        branch_taken_i  = 1'b1;
        branch_target_i = tgt;
        step();
        branch_taken_i  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        exc_i           = 1'b0;
        exc_target_i    = '0;
        inst_addr_ok    = 1'b0;
        inst_data_ok    = 1'b0;
        inst_rdata      = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Zero-wait sequential fetch.
        fetch_one(32'hbfc00000, 32'h11111111, 0, 0);
        fetch_one(32'hbfc00004, 32'h22222222, 0, 0);
        fetch_one(32'hbfc00008, 32'h33333333, 0, 0);

        // Slow response plus decode stall.
        fetch_one(32'hbfc0000c, 32'h44444444, 3, 4);

        // Branch during WAIT: delay slot delivered, then target.
        do_reset();
        fetch_one(32'hbfc00000, 32'h55555555, 0, 0);
        issue(32'hbfc00004);
        pulse_branch(32'h80001000);
        respond(32'h66666666, 0);
        expect_hold(32'h66666666, 32'hbfc00004, 0);
        fetch_one(32'h80001000, 32'h77777777, 0, 0);

        // Exception in WAIT: late response dropped.
        issue(32'h80001004);
        exc_i        = 1'b1;
        exc_target_i = 32'hbfc00380;
        step();
        exc_i        = 1'b0;
        respond(32'hdeaddead, 1);
        check("exc_drop_valid", W'(inst_valid_o), W'(0));
        step();
        check("exc_drop_valid2", W'(inst_valid_o), W'(0));
        fetch_one(32'hbfc00380, 32'h88888888, 0, 0);

        // Exception and branch together: branch lost.
        issue(32'hbfc00384);
        exc_i           = 1'b1;
        exc_target_i    = 32'hbfc00200;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h80002000;
        step();
        exc_i          = 1'b0;
        branch_taken_i = 1'b0;
        respond(32'hbadbad00, 0);
        check("both_valid", W'(inst_valid_o), W'(0));
        fetch_one(32'hbfc00200, 32'h99999999, 0, 0);
        issue(32'hbfc00204);

        // Reset while in WAIT.
        do_reset();

        // PC wraps modulo 2^32 after a branch to the top word.
        fetch_one(32'hbfc00000, 32'haaaaaaaa, 0, 0);
        issue(32'hbfc00004);
        pulse_branch(32'hfffffffc);
        respond(32'hbbbbbbbb, 0);
        expect_hold(32'hbbbbbbbb, 32'hbfc00004, 1);
        fetch_one(32'hfffffffc, 32'hcccccccc, 0, 0);
        issue(32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
